// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Definitions shared by the fetch stage and the stages that consume IF/ID:
//   the architectural word width, the bubble encoding (NOP) and the default
//   reset PC. Also provides the PC+4 helper (add4) so every user computes the
//   sequential address the same way.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int          MIPS_WORD_W   = 32;
    localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;
    localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

    // Sequential fetch address. Wraps modulo 2^32 by construction.
    function automatic logic [MIPS_WORD_W-1:0] add4(input logic [MIPS_WORD_W-1:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
//   IF/ID pipeline latch. Priority per clock edge: flush > hold > load.
//   A flush writes a bubble (NOP, pc4 = 0, valid = 0); hold keeps the current
//   contents unchanged; otherwise the fetched instruction is captured valid.
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (contents become a bubble)
//   hold_i    in   keep current contents
//   flush_i   in   replace contents with a bubble
//   instr_i   in   fetched instruction word
//   pc4_i     in   PC+4 of the fetched instruction
//   instr_o   out  latched instruction
//   pc4_o     out  latched PC+4
//   valid_o   out  1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_id_register
    import fetch_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold_i,
    input  logic                   flush_i,
    input  logic [MIPS_WORD_W-1:0] instr_i,
    input  logic [MIPS_WORD_W-1:0] pc4_i,
    output logic [MIPS_WORD_W-1:0] instr_o,
    output logic [MIPS_WORD_W-1:0] pc4_o,
    output logic                   valid_o
);

    logic [MIPS_WORD_W-1:0] instr_q, instr_d;
    logic [MIPS_WORD_W-1:0] pc4_q,   pc4_d;
    logic                   valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = MIPS_NOP;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= MIPS_NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch for the pipelined MIPS core. Owns the PC, addresses the
//   combinational instruction ROM and feeds the IF/ID register. Edge priority
//   is redirect > stall > sequential fetch. A redirect costs exactly one
//   bubble; a stall freezes PC, IF/ID and the fetch counter.
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   hold PC and IF/ID (load-use hazard in decode)
//   redirect     in   taken branch/jump: load redirect_pc and flush IF/ID
//   redirect_pc  in   byte target address, bits [1:0] ignored
//   imem_addr    out  ROM word address (pc[ADDR_W+1:2]), combinational
//   imem_data    in   ROM read data for imem_addr
//   pc           out  current fetch PC (byte address)
//   if_id_instr  out  latched instruction
//   if_id_pc4    out  latched PC+4 of that instruction
//   if_id_valid  out  1 = real instruction, 0 = bubble
//   fetch_count  out  number of instructions latched valid (wraps)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [MIPS_WORD_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [MIPS_WORD_W-1:0] imem_data,
    output logic [MIPS_WORD_W-1:0] pc,
    output logic [MIPS_WORD_W-1:0] if_id_instr,
    output logic [MIPS_WORD_W-1:0] if_id_pc4,
    output logic                   if_id_valid,
    output logic [CNT_W-1:0]       fetch_count
);

    logic [MIPS_WORD_W-1:0] pc_q, pc_d;
    logic [MIPS_WORD_W-1:0] pc_plus4;
    logic [CNT_W-1:0]       fetch_count_q, fetch_count_d;
    logic                   advance;
    logic                   unused_redirect_lsbs;

    assign pc_plus4 = add4(pc_q);
    assign advance  = !redirect && !stall;

    // Target LSBs are forced to zero, so pc[1:0] stays 00 from reset onward.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            pc_d = {redirect_pc[MIPS_WORD_W-1:2], 2'b00};
        end else if (!stall) begin
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= {RESET_PC[MIPS_WORD_W-1:2], 2'b00};
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Only the word-address bits reach the ROM; higher PC bits alias.
    assign imem_addr = pc_q[ADDR_W+1:2];

    if_id_register u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (!advance && !redirect),
        .flush_i (redirect),
        .instr_i (imem_data),
        .pc4_i   (pc_plus4),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valid)
    );

    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
        logic [15:0] cnt;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       pc;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc4;
    logic              if_id_valid;
    logic [CNT_W-1:0]  fetch_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    vec_t exp_q[$];

    // ROM contents: word i holds i + 100.
    assign imem_data = 32'd100 + {24'd0, imem_addr};

    fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input vec_t e);
        logic [31:0] exp_addr;
        exp_addr = {24'd0, e.pc[9:2]};
        check({tag, ".pc"},        pc,                  e.pc);
        check({tag, ".instr"},     if_id_instr,         e.instr);
        check({tag, ".pc4"},       if_id_pc4,           e.pc4);
        check({tag, ".valid"},     {31'd0, if_id_valid}, {31'd0, e.v});
        check({tag, ".count"},     {16'd0, fetch_count}, {16'd0, e.cnt});
        check({tag, ".imem_addr"}, {24'd0, imem_addr},   exp_addr);
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic [31:0] p, input logic [31:0] ins,
                                input logic [31:0] p4, input logic v, input logic [15:0] c);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.pc = p; r.instr = ins;
        r.pc4 = p4; r.v = v; r.cnt = c;
        return r;
    endfunction

    // Apply one vector for one edge, then post its hand-computed post-edge state.
    task automatic run_vec(input vec_t v);
        stall       = v.st;
        redirect    = v.rd;
        redirect_pc = v.rpc;
        @(posedge clk);
        exp_q.push_back(v);
        n_pushed++;
        #1;
    endtask

    // Async reset between edges, checked before any further clock edge.
    task automatic async_reset(input string tag);
        vec_t r;
        r = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        stall = 1'b0; redirect = 1'b0;
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1 check_state(tag, r);
        @(posedge clk);
        #2 check_state({tag, "_held"}, r);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a new IF/ID/PC state; compare it.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_popped++;
                check_state($sformatf("vec%0d", n_popped), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t seq_a[$];
    vec_t seq_b[$];
    vec_t seq_c[$];

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Free run from reset: pc 0 -> 16, ROM words 0..3 latched.
        seq_a.push_back(mk(0, 0, 0, 32'h04, 32'd100, 32'h04, 1, 16'd1));
        seq_a.push_back(mk(0, 0, 0, 32'h08, 32'd101, 32'h08, 1, 16'd2));
        seq_a.push_back(mk(0, 0, 0, 32'h0C, 32'd102, 32'h0C, 1, 16'd3));
        seq_a.push_back(mk(0, 0, 0, 32'h10, 32'd103, 32'h10, 1, 16'd4));

        // Stall at pc=8, redirect at pc=12, redirect+stall, ROM address wrap, PC wrap.
        seq_b.push_back(mk(0, 0, 0, 32'h04, 32'd100, 32'h04, 1, 16'd1));
        seq_b.push_back(mk(0, 0, 0, 32'h08, 32'd101, 32'h08, 1, 16'd2));
        seq_b.push_back(mk(1, 0, 0, 32'h08, 32'd101, 32'h08, 1, 16'd2));
        seq_b.push_back(mk(1, 0, 0, 32'h08, 32'd101, 32'h08, 1, 16'd2));
        seq_b.push_back(mk(1, 0, 0, 32'h08, 32'd101, 32'h08, 1, 16'd2));
        seq_b.push_back(mk(0, 0, 0, 32'h0C, 32'd102, 32'h0C, 1, 16'd3));
        seq_b.push_back(mk(0, 1, 32'h43, 32'h40, 32'h0, 32'h0, 0, 16'd3));
        seq_b.push_back(mk(0, 0, 0, 32'h44, 32'd116, 32'h44, 1, 16'd4));
        seq_b.push_back(mk(0, 0, 0, 32'h48, 32'd117, 32'h48, 1, 16'd5));
        seq_b.push_back(mk(1, 1, 32'h3FE, 32'h3FC, 32'h0, 32'h0, 0, 16'd5));
        seq_b.push_back(mk(0, 0, 0, 32'h400, 32'd355, 32'h400, 1, 16'd6));
        seq_b.push_back(mk(0, 0, 0, 32'h404, 32'd100, 32'h404, 1, 16'd7));
        seq_b.push_back(mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 16'd7));
        seq_b.push_back(mk(0, 0, 0, 32'h0, 32'd355, 32'h0, 1, 16'd8));
        seq_b.push_back(mk(1, 0, 0, 32'h0, 32'd355, 32'h0, 1, 16'd8));
        seq_b.push_back(mk(0, 0, 0, 32'h4, 32'd100, 32'h4, 1, 16'd9));

        // Resume after the second mid-run reset.
        seq_c.push_back(mk(0, 0, 0, 32'h04, 32'd100, 32'h04, 1, 16'd1));
        seq_c.push_back(mk(0, 0, 0, 32'h08, 32'd101, 32'h08, 1, 16'd2));

        #1 check_state("reset", mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0));
        #8 rst_n = 1'b1;

        foreach (seq_a[i]) run_vec(seq_a[i]);
        async_reset("midreset1");
        foreach (seq_b[i]) run_vec(seq_b[i]);
        async_reset("midreset2");
        foreach (seq_c[i]) run_vec(seq_c[i]);

        stall = 1'b0; redirect = 1'b0;
        repeat (3) @(posedge clk);
        n_checks++;
        if (n_popped != n_pushed || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: popped %0d expected %0d", n_popped, n_pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
